// File: rtl/regbank_alu_console.sv
// Button-stepped console: loads registers in IN_W chunks, runs one ALU op on the
// register bank, then shows the result a chunk at a time on the display word.
module regbank_alu_console #(
  parameter int DATA_W = 32,
  parameter int IN_W   = 16,
  parameter int NREG   = 32,
  parameter int NLOAD  = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [IN_W-1:0] in,
  input  logic            btn,
  output logic [IN_W-1:0] out,
  output logic            err
);

  localparam int NCH        = DATA_W / IN_W;
  localparam int AW         = $clog2(NREG);
  localparam int SW         = $clog2(DATA_W);
  localparam int LOAD_STEPS = NLOAD * (1 + NCH);
  localparam int REGS_STEP  = LOAD_STEPS;
  localparam int FUNCT_STEP = LOAD_STEPS + 1;
  localparam int T          = LOAD_STEPS + 2 + NCH;
  localparam int STW        = $clog2(T + 1);
  localparam int CW         = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [2:0] {
    PH_ADDR,
    PH_CHUNK,
    PH_REGS,
    PH_FUNCT,
    PH_DISP
  } phase_t;

  logic [DATA_W-1:0] regs [NREG];
  logic [STW-1:0]    step;
  logic              btn_q;
  logic              exec;
  logic [AW-1:0]     dr, rs, rt, rd;
  logic [3:0]        funct;
  logic [SW-1:0]     shamt;
  logic [DATA_W-1:0] res;
  logic [DATA_W-1:0] asm_word;

  phase_t            phase;
  logic [STW-1:0]    pos;
  logic [CW-1:0]     chunk_idx;
  logic [CW-1:0]     disp_idx;
  logic [DATA_W-1:0] wr_word;
  logic [DATA_W-1:0] op_a, op_b;
  logic [DATA_W-1:0] alu_res;
  logic              alu_err;
  logic              step_edge;

  assign step_edge = btn & ~btn_q;

  // Decode which kind of step the counter is sitting in.
  always_comb begin
    phase     = PH_DISP;
    chunk_idx = '0;
    disp_idx  = '0;
    pos       = step % STW'(NCH + 1);
    if (int'(step) < LOAD_STEPS) begin
      if (pos == '0) begin
        phase = PH_ADDR;
      end else begin
        phase     = PH_CHUNK;
        chunk_idx = CW'(pos - 1'b1);
      end
    end else if (int'(step) == REGS_STEP) begin
      phase = PH_REGS;
    end else if (int'(step) == FUNCT_STEP) begin
      phase = PH_FUNCT;
    end else begin
      disp_idx = CW'(step - STW'(FUNCT_STEP + 1));
    end
  end

  // The last chunk merges straight into the write word so the register sees it on that edge.
  always_comb begin
    wr_word = asm_word;
    wr_word[chunk_idx*IN_W +: IN_W] = in;
  end

  always_comb begin
    op_a    = regs[rs];
    op_b    = regs[rt];
    alu_res = '0;
    alu_err = 1'b0;
    case (funct)
      4'd0: alu_res = op_a + op_b;
      4'd1: alu_res = op_a - op_b;
      4'd2: alu_res = op_a & op_b;
      4'd3: alu_res = op_a | op_b;
      4'd4: alu_res = op_a ^ op_b;
      4'd5: alu_res = ~(op_a | op_b);
      4'd6: alu_res = op_b << shamt;
      4'd7: alu_res = op_b >> shamt;
      4'd8: alu_res = DATA_W'($signed(op_b) >>> shamt);
      4'd9: alu_res = DATA_W'($signed(op_a) < $signed(op_b));
      default: alu_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      step     <= '0;
      out      <= '0;
      err      <= 1'b0;
      res      <= '0;
      btn_q    <= 1'b0;
      exec     <= 1'b0;
      dr       <= '0;
      rs       <= '0;
      rt       <= '0;
      rd       <= '0;
      funct    <= '0;
      shamt    <= '0;
      asm_word <= '0;
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      btn_q <= btn;
      exec  <= step_edge && (phase == PH_FUNCT);
      // Execute lands a cycle after FUNCT; btn_q is high then, so no step edge can collide.
      if (exec) begin
        res <= alu_res;
        err <= alu_err;
        if (!alu_err) regs[rd] <= alu_res;
      end
      if (step_edge) begin
        step <= (int'(step) == T - 1) ? '0 : step + 1'b1;
        case (phase)
          PH_ADDR:  dr <= in[AW-1:0];
          PH_CHUNK: begin
            asm_word <= wr_word;
            if (chunk_idx == CW'(NCH - 1)) regs[dr] <= wr_word;
          end
          PH_REGS: begin
            rs <= in[3*AW-1:2*AW];
            rt <= in[2*AW-1:AW];
            rd <= in[AW-1:0];
          end
          PH_FUNCT: begin
            funct <= in[3:0];
            shamt <= in[4+SW-1:4];
          end
          default: ;
        endcase
        if (phase == PH_DISP) out <= res[disp_idx*IN_W +: IN_W];
        else                  out <= IN_W'(step) + IN_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_regbank_alu_console.sv
// Directed bench: a driver pushes expected display/err values per step, a monitor
// detects step edges on the pins and checks the DUT response against the queue.
module tb_regbank_alu_console;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic        btn   = 1'b0;
  logic [15:0] in    = '0;
  logic [15:0] out;
  logic        err;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [15:0] out;
    logic        err;
    bit          chk_err;
    string       name;
  } exp_t;

  exp_t exp_q[$];

  regbank_alu_console #(
    .DATA_W(32),
    .IN_W  (16),
    .NREG  (32),
    .NLOAD (2)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .in   (in),
    .btn  (btn),
    .out  (out),
    .err  (err)
  );

  always #5 clk = ~clk;

  // Monitor: an accepted step (or reset) at a rising edge means a response is due.
  logic mon_btn_q = 1'b0;
  logic mon_evt   = 1'b0;

  always @(posedge clk) begin
    mon_evt   <= reset | (btn & ~mon_btn_q);
    mon_btn_q <= reset ? 1'b0 : btn;
  end

  always @(negedge clk) begin
    if (mon_evt) checkOutput();
  end

  task automatic checkOutput();
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL unexpected_step: out=%h with nothing expected", out);
    end else begin
      e = exp_q.pop_front();
      checks++;
      if (out !== e.out) begin
        failures++;
        $display("[TB] FAIL %s: out=%h expected %h", e.name, out, e.out);
      end
      if (e.chk_err) begin
        checks++;
        if (err !== e.err) begin
          failures++;
          $display("[TB] FAIL %s_err: err=%b expected %b", e.name, err, e.err);
        end
      end
    end
  endtask

  task automatic pushExp(input logic [15:0] o, input logic e, input bit c, input string n);
    exp_t x;
    x.out = o; x.err = e; x.chk_err = c; x.name = n;
    exp_q.push_back(x);
  endtask

  task automatic applyStimulus(input logic [15:0] in_val, input logic [15:0] exp_out,
                               input logic exp_err, input bit chk_err, input string name);
    @(negedge clk);
    in = in_val;
    pushExp(exp_out, exp_err, chk_err, name);
    btn = 1'b1;
    @(negedge clk);
    btn = 1'b0;
    @(negedge clk);
  endtask

  task automatic resetDut(input string name);
    @(negedge clk);
    reset = 1'b1;
    pushExp(16'h0000, 1'b0, 1'b1, name);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // One full ten-step sequence with the hand-computed 32-bit result and err.
  task automatic runSeq(input logic [4:0] a1, input logic [31:0] w1,
                        input logic [4:0] a2, input logic [31:0] w2,
                        input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                        input logic [3:0] funct, input logic [4:0] shamt,
                        input logic [31:0] exp_res, input logic exp_err, input string tag);
    applyStimulus({11'b0, a1},            16'd1, 1'b0, 1'b0, {tag, "_addr1"});
    applyStimulus(w1[15:0],               16'd2, 1'b0, 1'b0, {tag, "_ld1_lo"});
    applyStimulus(w1[31:16],              16'd3, 1'b0, 1'b0, {tag, "_ld1_hi"});
    applyStimulus({11'b0, a2},            16'd4, 1'b0, 1'b0, {tag, "_addr2"});
    applyStimulus(w2[15:0],               16'd5, 1'b0, 1'b0, {tag, "_ld2_lo"});
    applyStimulus(w2[31:16],              16'd6, 1'b0, 1'b0, {tag, "_ld2_hi"});
    applyStimulus({1'b0, rs, rt, rd},     16'd7, 1'b0, 1'b0, {tag, "_regs"});
    applyStimulus({7'b0, shamt, funct},   16'd8, 1'b0, 1'b0, {tag, "_funct"});
    applyStimulus(16'h0000, exp_res[15:0],  exp_err, 1'b1, {tag, "_disp_lo"});
    applyStimulus(16'h0000, exp_res[31:16], exp_err, 1'b1, {tag, "_disp_hi"});
  endtask

  initial begin
    $display("[TB] start");
    pushExp(16'h0000, 1'b0, 1'b1, "reset_state");
    @(negedge clk);
    reset = 1'b0;

    runSeq(5'd3, 32'h0000_0007, 5'd4, 32'hFFFF_FFFE, 5'd3, 5'd4, 5'd5, 4'd0, 5'd0, 32'h0000_0005, 1'b0, "add");
    runSeq(5'd6, 32'h0, 5'd7, 32'h0, 5'd5, 5'd0, 5'd8, 4'd0, 5'd0, 32'h0000_0005, 1'b0, "r5_readback");
    runSeq(5'd3, 32'h0000_0007, 5'd4, 32'hFFFF_FFFE, 5'd3, 5'd4, 5'd9, 4'd1, 5'd0, 32'h0000_0009, 1'b0, "sub");
    runSeq(5'd3, 32'h0000_0007, 5'd4, 32'hFFFF_FFFE, 5'd3, 5'd4, 5'd10, 4'd9, 5'd0, 32'h0000_0000, 1'b0, "slt");
    runSeq(5'd3, 32'h0000_0007, 5'd4, 32'hFFFF_FFFE, 5'd3, 5'd4, 5'd11, 4'd8, 5'd1, 32'hFFFF_FFFF, 1'b0, "sra");
    runSeq(5'd3, 32'h0000_0007, 5'd4, 32'hFFFF_FFFE, 5'd3, 5'd4, 5'd11, 4'd7, 5'd1, 32'h7FFF_FFFF, 1'b0, "srl");
    runSeq(5'd3, 32'h0000_0007, 5'd4, 32'hFFFF_FFFE, 5'd3, 5'd4, 5'd5, 4'd12, 5'd0, 32'h0000_0000, 1'b1, "undef");
    runSeq(5'd6, 32'h0, 5'd7, 32'h0, 5'd5, 5'd0, 5'd12, 4'd3, 5'd0, 32'h0000_0005, 1'b0, "or_clear");
    runSeq(5'd1, 32'h1234_5678, 5'd2, 32'h0F0F_0F0F, 5'd1, 5'd2, 5'd13, 4'd4, 5'd0, 32'h1D3B_5977, 1'b0, "xor");
    runSeq(5'd1, 32'h1234_5678, 5'd2, 32'h0F0F_0F0F, 5'd1, 5'd2, 5'd14, 4'd6, 5'd4, 32'hF0F0_F0F0, 1'b0, "sll");
    runSeq(5'd1, 32'h1234_5678, 5'd2, 32'h0, 5'd1, 5'd1, 5'd1, 4'd5, 5'd0, 32'hEDCB_A987, 1'b0, "nor_same");
    runSeq(5'd6, 32'h0, 5'd7, 32'h0, 5'd1, 5'd1, 5'd2, 4'd2, 5'd0, 32'hEDCB_A987, 1'b0, "and_readback");

    // Held button: one step only.
    @(negedge clk);
    in = 16'd3;
    pushExp(16'd1, 1'b0, 1'b0, "held_btn");
    btn = 1'b1;
    repeat (20) @(negedge clk);
    btn = 1'b0;
    @(negedge clk);
    applyStimulus(16'h1234, 16'd2, 1'b0, 1'b0, "after_hold_chunk");

    // Reset in the middle of load 1 abandons it; r3 must read back as zero.
    resetDut("mid_reset");
    runSeq(5'd6, 32'h0, 5'd7, 32'h0, 5'd3, 5'd0, 5'd8, 4'd0, 5'd0, 32'h0000_0000, 1'b0, "post_reset");

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL drain: %0d responses outstanding, expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
